// File: rtl/axi_master_pkg.sv
// Shared encodings for the AXI master bridge: FSM states and AXI SIZE/BURST/RESP codes.
package axi_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    WRESP = 3'd4
  } state_e;

  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/pkg_include.sv
// AXI4 interface bundle (32-bit data, 4-bit strobe, 4-bit IDs) and width macros.
`ifndef PKG_INCLUDE_SV
`define PKG_INCLUDE_SV

`define AXI_ADDR_W 32
`define AXI_DATA_W 32
`define AXI_ID_W   4

interface AXI_master_intf;
  logic [`AXI_ID_W-1:0]     awid;
  logic [`AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]               awlen;
  logic [2:0]               awsize;
  logic [1:0]               awburst;
  logic                     awvalid;
  logic                     awready;
  logic [`AXI_DATA_W-1:0]   wdata;
  logic [`AXI_DATA_W/8-1:0] wstrb;
  logic                     wlast;
  logic                     wvalid;
  logic                     wready;
  logic [`AXI_ID_W-1:0]     bid;
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;
  logic [`AXI_ID_W-1:0]     arid;
  logic [`AXI_ADDR_W-1:0]   araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;
  logic [`AXI_ID_W-1:0]     rid;
  logic [`AXI_DATA_W-1:0]   rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

`endif

// File: rtl/axi_master_bridge.sv
// Single-beat CPU-request to AXI4 master bridge; one outstanding transaction, no queueing.
// Define AXI_MASTER_ERR_EN to add err_o, flagging a non-OKAY RRESP/BRESP on completion.
module axi_master_bridge
  import axi_master_pkg::*;
#(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic           clk,
  input  logic           rstn,
  AXI_master_intf.master master,
  input  logic           req_i,
  input  logic           write_i,
  input  logic [31:0]    addr_i,
  input  logic [31:0]    wdata_i,
  input  logic [3:0]     wstrb_i,
  output logic           req_ready_o,
  output logic [31:0]    rdata_o,
  output logic           done_o
`ifdef AXI_MASTER_ERR_EN
  ,
  output logic           err_o
`endif
);

  state_e      state_r;
  state_e      state_s;
  logic        write_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        aw_done_r;
  logic        w_done_r;
  logic [31:0] rdata_r;
  logic        done_r;
  logic        accept_s;
  logic        aw_hs_s;
  logic        w_hs_s;
  logic        ar_hs_s;
  logic        r_hs_s;
  logic        b_hs_s;
  logic        rd_fin_s;
  logic        wr_fin_s;

  assign accept_s = req_i & (state_r == IDLE);
  assign aw_hs_s  = master.awvalid & master.awready;
  assign w_hs_s   = master.wvalid & master.wready;
  assign ar_hs_s  = master.arvalid & master.arready;
  assign r_hs_s   = master.rvalid & master.rready;
  assign b_hs_s   = master.bvalid & master.bready;
  // An RVALID beat without RLAST is consumed but never completes the read.
  assign rd_fin_s = (state_r == RDATA) & r_hs_s & master.rlast;
  assign wr_fin_s = (state_r == WRESP) & b_hs_s;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_i) begin
          if (write_i) state_s = WRITE;
          else         state_s = RADDR;
        end else begin
          state_s = IDLE;
        end
      end
      RADDR: begin
        if (ar_hs_s) state_s = RDATA;
        else         state_s = RADDR;
      end
      RDATA: begin
        if (rd_fin_s) state_s = IDLE;
        else          state_s = RDATA;
      end
      WRITE: begin
        if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) state_s = WRESP;
        else                                             state_s = WRITE;
      end
      WRESP: begin
        if (wr_fin_s) state_s = IDLE;
        else          state_s = WRESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Request capture on acceptance; the AXI payload is driven only from these copies.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_r <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      wstrb_r <= 4'd0;
    end else if (accept_s) begin
      write_r <= write_i;
      addr_r  <= addr_i;
      wdata_r <= wdata_i;
      wstrb_r <= wstrb_i;
    end
  end

  // AW/W completion flags, cleared whenever the FSM is outside WRITE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (state_r == WRITE) begin
      if (aw_hs_s) aw_done_r <= 1'b1;
      if (w_hs_s)  w_done_r  <= 1'b1;
    end else begin
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end
  end

  // Read data and completion pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_r <= 32'd0;
      done_r  <= 1'b0;
    end else begin
      if (rd_fin_s) rdata_r <= master.rdata;
      done_r <= rd_fin_s | wr_fin_s;
    end
  end

`ifdef AXI_MASTER_ERR_EN
  logic err_r;

  // Error flag pulses alongside done_o for a non-OKAY completing response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_r <= 1'b0;
    else       err_r <= (rd_fin_s & resp_is_err(master.rresp)) |
                        (wr_fin_s & resp_is_err(master.bresp));
  end

  assign err_o = err_r;
`endif

  assign req_ready_o = (state_r == IDLE);
  assign rdata_o     = rdata_r;
  assign done_o      = done_r;

  assign master.awid    = MASTER_ID;
  assign master.awaddr  = addr_r;
  assign master.awlen   = 8'd0;
  assign master.awsize  = AXI_SIZE_4B;
  assign master.awburst = AXI_BURST_INCR;
  assign master.awvalid = (state_r == WRITE) & write_r & ~aw_done_r;
  assign master.wdata   = wdata_r;
  assign master.wstrb   = wstrb_r;
  assign master.wlast   = 1'b1;
  assign master.wvalid  = (state_r == WRITE) & write_r & ~w_done_r;
  assign master.bready  = (state_r == WRESP);
  assign master.arid    = MASTER_ID;
  assign master.araddr  = addr_r;
  assign master.arlen   = 8'd0;
  assign master.arsize  = AXI_SIZE_4B;
  assign master.arburst = AXI_BURST_INCR;
  assign master.arvalid = (state_r == RADDR) & ~write_r;
  assign master.rready  = (state_r == RDATA);

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed self-checking bench for axi_master_bridge; the slave side is driven by hand.
module tb_axi_master_bridge;

  logic        clk;
  logic        rstn;
  logic        req_i;
  logic        write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        req_ready_o;
  logic [31:0] rdata_o;
  logic        done_o;
`ifdef AXI_MASTER_ERR_EN
  logic        err_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  int ar_hs_cnt = 0;
  int done_cnt = 0;
  int hs0;
  int d0;

  AXI_master_intf axi ();

  axi_master_bridge #(.MASTER_ID(4'd5)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .master     (axi),
    .req_i      (req_i),
    .write_i    (write_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .wstrb_i    (wstrb_i),
    .req_ready_o(req_ready_o),
    .rdata_o    (rdata_o),
    .done_o     (done_o)
`ifdef AXI_MASTER_ERR_EN
    ,
    .err_o      (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (axi.arvalid && axi.arready) ar_hs_cnt <= ar_hs_cnt + 1;
    if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Write with AW and W accepted in the same cycle and BVALID waiting in WRESP.
  task automatic do_write_fast(input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] resp, input logic exp_err);
    req_i = 1'b1; write_i = 1'b1; addr_i = a; wdata_i = d; wstrb_i = 4'hF;
    axi.awready = 1'b1; axi.wready = 1'b1;
    tick();
    req_i = 1'b0;
    chk("wf_aw_w_valid", 32'({axi.awvalid, axi.wvalid, axi.bready}), 32'd6);
    chk("wf_awaddr", axi.awaddr, a);
    axi.bvalid = 1'b1; axi.bresp = resp;
    tick();
    axi.awready = 1'b0; axi.wready = 1'b0;
    chk("wf_wresp", 32'({axi.awvalid, axi.wvalid, axi.bready, done_o}), 32'd2);
    tick();
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    chk("wf_done", 32'(done_o), 32'd1);
`ifdef AXI_MASTER_ERR_EN
    chk("wf_err", 32'(err_o), 32'(exp_err));
`else
    if (exp_err) $display("note: err_o not built");
`endif
    tick();
    chk("wf_done_drop", 32'(done_o), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; req_i = 1'b0; write_i = 1'b0;
    addr_i = 32'd0; wdata_i = 32'd0; wstrb_i = 4'd0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bid = 4'd0; axi.bresp = 2'b00; axi.bvalid = 1'b0;
    axi.rid = 4'd0; axi.rdata = 32'd0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    tick();
    tick();
    chk("rst_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.rready, axi.bready}), 32'd0);
    chk("rst_outs", 32'({req_ready_o, done_o}), 32'd2);
    chk("rst_rdata", rdata_o, 32'd0);
    rstn = 1'b1;

    // Read with ARREADY held off for three cycles.
    req_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0010;
    tick();
    req_i = 1'b0; addr_i = 32'hFFFF_FFFF;
    chk("rd_busy_ready", 32'(req_ready_o), 32'd0);
    chk("ar_ctrl", 32'({axi.arid, axi.arlen, axi.arsize, axi.arburst}), 32'({4'd5, 8'd0, 3'b010, 2'b01}));
    for (int i = 0; i < 3; i++) begin
      chk("ar_valid_wait", 32'(axi.arvalid), 32'd1);
      chk("ar_addr_stable", axi.araddr, 32'h0000_0010);
      tick();
    end
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("rd_phase", 32'({axi.arvalid, axi.rready, done_o}), 32'd2);
    axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF; axi.rlast = 1'b1; axi.rid = 4'd9;
    tick();
    axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rlast = 1'b0;
    chk("rd_done", 32'(done_o), 32'd1);
    chk("rd_data", rdata_o, 32'hDEAD_BEEF);
    chk("rd_idle_ready", 32'(req_ready_o), 32'd1);
    tick();
    chk("rd_done_one_cycle", 32'(done_o), 32'd0);

    // Write: AW accepted in cycle 1, W accepted in cycle 4.
    req_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0020; wdata_i = 32'h1234_5678; wstrb_i = 4'b0011;
    tick();
    req_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0; wstrb_i = 4'd0;
    chk("wr_c1_valids", 32'({axi.awvalid, axi.wvalid, axi.bready}), 32'd6);
    chk("wr_awaddr", axi.awaddr, 32'h0000_0020);
    chk("wr_wdata", axi.wdata, 32'h1234_5678);
    chk("wr_strb_last", 32'({axi.wstrb, axi.wlast}), 32'({4'b0011, 1'b1}));
    chk("aw_ctrl", 32'({axi.awid, axi.awlen, axi.awsize, axi.awburst}), 32'({4'd5, 8'd0, 3'b010, 2'b01}));
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_w_held", 32'({axi.awvalid, axi.wvalid, axi.bready}), 32'd2);
      if (i == 2) axi.wready = 1'b1;
      tick();
    end
    axi.wready = 1'b0;
    chk("wr_bready", 32'({axi.awvalid, axi.wvalid, axi.bready, done_o}), 32'd2);
    axi.bvalid = 1'b1; axi.bresp = 2'b00; axi.bid = 4'd3;
    tick();
    axi.bvalid = 1'b0;
    chk("wr_done", 32'(done_o), 32'd1);
    chk("wr_rdata_kept", rdata_o, 32'hDEAD_BEEF);

    // Same-cycle AW/W handshake, BVALID immediately.
    tick();
    do_write_fast(32'h0000_0030, 32'hCAFE_0030, 2'b00, 1'b0);

    // req_i held high across a busy read, including a non-RLAST beat.
    hs0 = ar_hs_cnt;
    req_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0040; axi.arready = 1'b1;
    tick();
    chk("hold_raddr_ready", 32'(req_ready_o), 32'd0);
    tick();
    axi.rvalid = 1'b1; axi.rlast = 1'b0; axi.rdata = 32'hBAD0_0BAD;
    tick();
    chk("nolast_stays", 32'({axi.rready, done_o, req_ready_o}), 32'd4);
    chk("nolast_rdata", rdata_o, 32'hDEAD_BEEF);
    axi.rlast = 1'b1; axi.rdata = 32'hA5A5_0001;
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    chk("hold_done1", 32'({done_o, req_ready_o}), 32'd3);
    chk("hold_rdata1", rdata_o, 32'hA5A5_0001);
    tick();
    chk("hold_second_ar", 32'({axi.arvalid, done_o}), 32'd2);
    tick();
    axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'hA5A5_0002;
    tick();
    req_i = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    chk("hold_done2", 32'(done_o), 32'd1);
    chk("hold_rdata2", rdata_o, 32'hA5A5_0002);
    tick();
    tick();
    axi.arready = 1'b0;
    chk("hold_ar_hs_twice", 32'(ar_hs_cnt - hs0), 32'd2);

    // Reset asserted mid-write while AWVALID is high.
    req_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0050; wdata_i = 32'h5555_5555; wstrb_i = 4'hF;
    tick();
    req_i = 1'b0;
    chk("mid_awvalid", 32'(axi.awvalid), 32'd1);
    d0 = done_cnt;
    #2 rstn = 1'b0;
    #1;
    chk("async_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.rready, axi.bready}), 32'd0);
    chk("async_rdata", rdata_o, 32'd0);
    tick();
    tick();
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_idle", 32'(req_ready_o), 32'd1);
    rstn = 1'b1;
    do_write_fast(32'h0000_0060, 32'h6666_6666, 2'b00, 1'b0);
    chk("post_rst_one_done", 32'(done_cnt - d0), 32'd1);

`ifdef AXI_MASTER_ERR_EN
    // SLVERR on a read raises err_o with done_o.
    req_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0070; axi.arready = 1'b1;
    tick();
    req_i = 1'b0;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h0BAD_0070; axi.rresp = 2'b10;
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    chk("err_rd", 32'({done_o, err_o}), 32'd3);
    tick();
    chk("err_rd_drop", 32'({done_o, err_o}), 32'd0);
    do_write_fast(32'h0000_0080, 32'h8888_8888, 2'b00, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_master_bridge.md
AXI_MASTER_BRIDGE -- requirements
Module: axi_master_bridge

Interface
REQ-001 SHALL have parameter MASTER_ID, default 4'd0: constant driven on AWID/ARID.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port master  AXI_master_intf.master  bundle: AXI4 master side (AW/W/B/AR/R channels, 32-bit data, 4-bit strobe).
REQ-005 SHALL have port req_i  input  1: CPU request valid.
REQ-006 SHALL have port write_i  input  1: 1 = write, 0 = read.
REQ-007 SHALL have port addr_i  input  32: byte address.
REQ-008 SHALL have port wdata_i  input  32: write data.
REQ-009 SHALL have port wstrb_i  input  4: byte enables for a write.
REQ-010 SHALL have port req_ready_o  output  1: request accepted this cycle when high together with req_i.
REQ-011 SHALL have port rdata_o  output  32: read data, registered.
REQ-012 SHALL have port done_o  output  1: one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, RADDR, RDATA, WRITE, WRESP.
REQ-014 SHALL assert req_ready_o only in IDLE; req_i in any other state is ignored (no queueing).
REQ-015 SHALL latch addr_i, wdata_i, wstrb_i and write_i on acceptance; IDLE->WRITE if write_i, else IDLE->RADDR.
REQ-016 SHALL drive single-beat transfers: LEN=0, SIZE=3'b010, BURST=INCR, ID=MASTER_ID, WLAST=1, from latched values only.
REQ-017 SHALL hold every VALID high with stable payload until its READY handshake; no VALID may depend combinationally on READY.
REQ-018 SHALL in RADDR assert ARVALID; on ARVALID&ARREADY go to RDATA.
REQ-019 SHALL in RDATA assert RREADY; on RVALID&RREADY&RLAST capture RDATA into rdata_o, pulse done_o next cycle, return to IDLE.
REQ-020 SHALL in WRITE assert AWVALID and WVALID together in its first cycle, drop each independently after its handshake (tracked by two flags), and go to WRESP the cycle both handshakes are complete, including both in the same cycle.
REQ-021 SHALL in WRESP assert BREADY; on BVALID&BREADY pulse done_o next cycle and return to IDLE.
REQ-022 SHALL hold rdata_o unchanged except on a read completion; writes never alter it.
REQ-023 SHALL keep done_o high exactly one cycle per transaction; earliest new acceptance is the cycle done_o is high.
REQ-024 SHALL ignore BID/RID values and treat any RVALID beat with RLAST low as a protocol error (beat consumed, state unchanged).

Reset
REQ-025 SHALL on rstn low, including mid-transaction, immediately force IDLE, all VALID/READY outputs 0, rdata_o 0, done_o 0, flags 0, latched request 0; an interrupted transaction is abandoned without done_o.

Configuration
REQ-026 SHALL, with AXI_MASTER_ERR_EN defined, add output err_o (1 bit) pulsing with done_o when the completing RRESP/BRESP is not OKAY.
REQ-027 SHALL, without AXI_MASTER_ERR_EN, omit err_o and ignore RRESP/BRESP; all other behaviour identical.

Structure
REQ-028 SHALL place the state enum and the SIZE/BURST/RESP encodings in shared package axi_master_pkg, imported by the module.
REQ-029 SHALL be a single module with no sub-modules; the AXI interface and macros come from the existing pkg_include.sv.

Verification
REQ-030 Read: req_i=1, write_i=0, addr_i=32'h0000_0010, slave ARREADY delayed 3 cycles, returns RDATA=32'hDEAD_BEEF -> ARADDR=32'h10 stable while waiting, rdata_o=32'hDEADBEEF, one done_o pulse.
REQ-031 Write: addr_i=32'h0000_0020, wdata_i=32'h1234_5678, wstrb_i=4'b0011, AWREADY at cycle 1, WREADY at cycle 4 -> AWVALID drops after cycle 1, WVALID held to cycle 4, BREADY only afterwards, done_o after B handshake, rdata_o unchanged.
REQ-032 Same-cycle AW/W handshake with BVALID following immediately -> WRESP entered next cycle, total 3 cycles acceptance-to-done_o.
REQ-033 req_i held high during a busy read -> second request accepted only in the done_o cycle; exactly two AR handshakes.
REQ-034 rstn pulled low while in WRITE with AWVALID high -> all VALIDs 0 asynchronously, no done_o, next request after release completes normally.
REQ-035 With AXI_MASTER_ERR_EN, slave returns RRESP=2'b10 -> err_o and done_o pulse together; BRESP=OKAY write -> err_o stays 0.
